// File: rtl/acc_column_sequencer.sv
// acc_column_sequencer: DDR/DDC line strobes and column stepping for the column accumulator
module acc_column_sequencer #(
    parameter int SAMPLES  = 512,
    parameter int DIV      = 8,
    parameter int GAP      = 16,
    parameter int NUM_COLS = 256,
    parameter int COL_W    = 8,
    parameter int IT_W     = 6
) (
    input  logic             ClockFromGen,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic [IT_W-1:0]  IterCount,
    input  logic             OutReady,
    output logic [COL_W-1:0] Column,
    output logic             DDR,
    output logic             DDC,
    output logic             Busy,
    output logic [IT_W-1:0]  IterIdx,
    output logic             ColumnDone,
    output logic             ScanDone
);
    localparam int CMAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int SW   = $clog2(SAMPLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SAMP, S_TAIL, S_GAP, S_DRAIN} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [SW-1:0]    samp, samp_n;
    logic [IT_W-1:0]  it, it_n, iter_n;
    logic [COL_W-1:0] col_n;
    logic             cdone_n, sdone_n;

    // State, counters and outputs; strobes are registered from the next state so they align with it
    always_ff @(posedge ClockFromGen or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            samp       <= '0;
            it         <= '0;
            Column     <= '0;
            IterIdx    <= '0;
            DDR        <= 1'b0;
            DDC        <= 1'b0;
            Busy       <= 1'b0;
            ColumnDone <= 1'b0;
            ScanDone   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            samp       <= samp_n;
            it         <= it_n;
            Column     <= col_n;
            IterIdx    <= iter_n;
            DDR        <= state_n inside {S_LEAD, S_SAMP, S_TAIL};
            DDC        <= (state_n == S_SAMP) && (cnt_n < CW'(DIV / 2));
            Busy       <= state_n != S_IDLE;
            ColumnDone <= cdone_n;
            ScanDone   <= sdone_n;
        end
    end

    // Line sequencing: LEAD, SAMPLES pulses, TAIL, GAP, then repeat, advance column or stop
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        samp_n  = samp;
        it_n    = it;
        col_n   = Column;
        iter_n  = IterIdx;
        cdone_n = 1'b0;
        sdone_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_n = S_LEAD;
                    cnt_n   = '0;
                    col_n   = '0;
                    iter_n  = '0;
                    it_n    = (IterCount == '0) ? IT_W'(1) : IterCount;
                end
            end
            S_LEAD: begin
                if (cnt == CW'(DIV - 1)) begin
                    state_n = S_SAMP;
                    cnt_n   = '0;
                    samp_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SAMP: begin
                if (cnt == CW'(DIV / 2 - 1) && samp != SW'(SAMPLES))
                    samp_n = samp + 1'b1;
                if (cnt != CW'(DIV - 1)) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (samp == SW'(SAMPLES))
                        state_n = S_TAIL;
                end
            end
            S_TAIL: begin
                if (cnt == CW'(DIV - 1)) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                    iter_n  = (&IterIdx) ? IterIdx : IterIdx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt != CW'(GAP - 1)) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (Stop) begin
                        state_n = S_IDLE;
                    end else if (IterIdx < it) begin
                        state_n = S_LEAD;
                    end else if (Column < COL_W'(NUM_COLS - 1)) begin
                        state_n = S_DRAIN;
                        col_n   = Column + 1'b1;
                        iter_n  = '0;
                        cdone_n = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cdone_n = 1'b1;
                        sdone_n = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (Stop) begin
                    state_n = S_IDLE;
                end else if (OutReady) begin
                    state_n = S_LEAD;
                    cnt_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_acc_column_sequencer.sv
// tb_acc_column_sequencer: scoreboard bench for the column sequencer line/column timing
module tb_acc_column_sequencer;
    localparam int SAMPLES  = 4;
    localparam int DIV      = 4;
    localparam int GAP      = 2;
    localparam int NUM_COLS = 3;
    localparam int COL_W    = 8;
    localparam int IT_W     = 6;
    localparam int LINE_HI  = 2 * DIV + SAMPLES * DIV;

    logic             ClockFromGen = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             Stop = 1'b0;
    logic [IT_W-1:0]  IterCount = '0;
    logic             OutReady = 1'b1;
    logic [COL_W-1:0] Column;
    logic             DDR, DDC, Busy, ColumnDone, ScanDone;
    logic [IT_W-1:0]  IterIdx;

    acc_column_sequencer #(
        .SAMPLES(SAMPLES), .DIV(DIV), .GAP(GAP), .NUM_COLS(NUM_COLS), .COL_W(COL_W), .IT_W(IT_W)
    ) dut (
        .ClockFromGen(ClockFromGen), .Reset(Reset), .Start(Start), .Stop(Stop),
        .IterCount(IterCount), .OutReady(OutReady), .Column(Column), .DDR(DDR), .DDC(DDC),
        .Busy(Busy), .IterIdx(IterIdx), .ColumnDone(ColumnDone), .ScanDone(ScanDone)
    );

    always #5 ClockFromGen = ~ClockFromGen;

    typedef struct {int col; int iter;} line_t;
    line_t exp_q[$];

    int errors = 0;
    int checks = 0;
    logic prev_ddr = 1'b0, prev_ddc = 1'b0;
    int hi_len, pulses, hi_run, lo_run, col_line;
    bit col_moved, bad_shape, ddc_out;
    int cd_cnt = 0, sd_cnt = 0;

    task automatic push_scan(input int itc);
        int eff = (itc == 0) ? 1 : itc;
        for (int c = 0; c < NUM_COLS; c++)
            for (int i = 1; i <= eff; i++)
                exp_q.push_back('{col: c, iter: i});
    endtask

    task automatic observe();
        line_t e;
        if (ColumnDone) cd_cnt++;
        if (ScanDone) sd_cnt++;
        if (DDC && !DDR) ddc_out = 1;
        if (DDR && !prev_ddr) begin
            hi_len = 0; pulses = 0; hi_run = 0; lo_run = 0;
            col_line = int'(Column); col_moved = 0; ddc_out = 0;
            bad_shape = (DDC !== 1'b0);
        end
        if (DDR) begin
            hi_len++;
            if (int'(Column) != col_line) col_moved = 1;
        end
        if (DDR && DDC && !prev_ddc) begin
            if (pulses == 0 && hi_len != DIV + 1) bad_shape = 1;
            if (pulses > 0 && lo_run != DIV / 2) bad_shape = 1;
            pulses++;
            hi_run = 0;
        end
        if (DDC) hi_run++;
        if (!DDC && prev_ddc) begin
            if (hi_run != DIV / 2) bad_shape = 1;
            lo_run = 0;
        end
        if (!DDC) lo_run++;
        if (!DDR && prev_ddr) begin
            if (lo_run != DIV / 2 + DIV + 1) bad_shape = 1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected: got line col=%0d iter=%0d, no line expected", col_line, IterIdx);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (hi_len != LINE_HI) begin errors++; $display("FAIL ddr_len: got %0d, want %0d", hi_len, LINE_HI); end
                checks++;
                if (pulses != SAMPLES) begin errors++; $display("FAIL ddc_count: got %0d, want %0d", pulses, SAMPLES); end
                checks++;
                if (bad_shape || ddc_out) begin errors++; $display("FAIL ddc_shape: shape_err=%0b ddc_outside=%0b, want 0/0", bad_shape, ddc_out); end
                checks++;
                if (col_line != e.col || col_moved) begin errors++; $display("FAIL line_column: got %0d moved=%0b, want %0d", col_line, col_moved, e.col); end
                if (int'(IterIdx) != e.iter) begin errors++; $display("FAIL line_iteridx: got %0d, want %0d", IterIdx, e.iter); end
            end
        end
        prev_ddr = DDR;
        prev_ddc = DDC;
    endtask

    task automatic tick();
        @(posedge ClockFromGen);
        #1;
        observe();
    endtask

    task automatic pulse_start(input int itc);
        IterCount = IT_W'(itc);
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (Busy && n < budget) begin tick(); n++; end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%0b after %0d cycles, want 0", name, Busy, n); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_lines: %0d expected lines unseen, want 0", name, exp_q.size()); end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({DDR, DDC, Busy, ColumnDone, ScanDone} !== 5'b0 || Column !== '0 || IterIdx !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ddr=%b ddc=%b busy=%b cd=%b sd=%b col=%0d it=%0d, want all 0",
                     DDR, DDC, Busy, ColumnDone, ScanDone, Column, IterIdx);
        end
        Reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (Busy !== 1'b0 || DDR !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b ddr=%b, want 0/0", Busy, DDR); end
    endtask

    task automatic test_first_line();
        int n = 0, lo = 1, cd0 = cd_cnt;
        exp_q.push_back('{col: 0, iter: 1});
        exp_q.push_back('{col: 0, iter: 2});
        pulse_start(2);
        checks++;
        if (DDR !== 1'b1 || Busy !== 1'b1 || Column !== '0) begin
            errors++;
            $display("FAIL first_rise: ddr=%b busy=%b col=%0d, want 1/1/0", DDR, Busy, Column);
        end
        while (DDR && n < 100) begin tick(); n++; end
        while (n < 100) begin
            tick(); n++;
            if (DDR) break;
            lo++;
        end
        checks++;
        if (lo != GAP || DDR !== 1'b1) begin errors++; $display("FAIL first_gap: low=%0d ddr=%b, want %0d then 1", lo, DDR, GAP); end
        Stop = 1'b1;
        wait_idle(100, "first");
        Stop = 1'b0;
        checks++;
        if (Column !== '0 || IterIdx !== IT_W'(2) || cd_cnt != cd0) begin
            errors++;
            $display("FAIL first_stop: col=%0d it=%0d cd=%0d, want 0/2/0", Column, IterIdx, cd_cnt - cd0);
        end
    endtask

    task automatic test_full_scan();
        int cd0 = cd_cnt, sd0 = sd_cnt;
        push_scan(2);
        pulse_start(2);
        wait_idle(400, "full");
        checks++;
        if (cd_cnt - cd0 != NUM_COLS || sd_cnt - sd0 != 1) begin
            errors++;
            $display("FAIL full_pulses: coldone=%0d scandone=%0d, want %0d/1", cd_cnt - cd0, sd_cnt - sd0, NUM_COLS);
        end
        checks++;
        if (Column !== COL_W'(NUM_COLS - 1) || IterIdx !== IT_W'(2)) begin
            errors++;
            $display("FAIL full_hold: col=%0d it=%0d, want %0d/2", Column, IterIdx, NUM_COLS - 1);
        end
    endtask

    task automatic test_drain();
        int n = 0, hi = 0, cd0 = cd_cnt;
        exp_q.push_back('{col: 0, iter: 1});
        exp_q.push_back('{col: 0, iter: 2});
        pulse_start(2);
        while (cd_cnt == cd0 && n < 200) begin tick(); n++; end
        checks++;
        if (cd_cnt == cd0) begin errors++; $display("FAIL drain_advance: no ColumnDone in %0d cycles, want 1", n); end
        OutReady = 1'b0;
        repeat (50) begin tick(); if (DDR) hi++; end
        checks++;
        if (hi != 0 || Busy !== 1'b1 || Column !== COL_W'(1)) begin
            errors++;
            $display("FAIL drain_hold: ddr_high=%0d busy=%b col=%0d, want 0/1/1", hi, Busy, Column);
        end
        OutReady = 1'b1;
        tick();
        checks++;
        if (DDR !== 1'b1 || Column !== COL_W'(1)) begin errors++; $display("FAIL drain_lead: ddr=%b col=%0d, want 1/1", DDR, Column); end
        for (int c = 1; c < NUM_COLS; c++)
            for (int i = 1; i <= 2; i++)
                exp_q.push_back('{col: c, iter: i});
        wait_idle(400, "drain");
    endtask

    task automatic test_stop_mid();
        int n = 0, cd0 = cd_cnt;
        exp_q.push_back('{col: 0, iter: 1});
        pulse_start(2);
        while (!DDC && n < 50) begin tick(); n++; end
        checks++;
        if (DDC !== 1'b1) begin errors++; $display("FAIL stop_ddc: ddc=%b after %0d cycles, want 1", DDC, n); end
        Stop = 1'b1;
        wait_idle(100, "stop");
        Stop = 1'b0;
        checks++;
        if (Column !== '0 || IterIdx !== IT_W'(1) || cd_cnt != cd0) begin
            errors++;
            $display("FAIL stop_state: col=%0d it=%0d cd=%0d, want 0/1/0", Column, IterIdx, cd_cnt - cd0);
        end
    endtask

    task automatic test_start_busy();
        int cd0 = cd_cnt, sd0 = sd_cnt;
        push_scan(1);
        pulse_start(1);
        repeat (10) tick();
        IterCount = IT_W'(5);
        Start = 1'b1; tick(); Start = 1'b0;
        repeat (40) tick();
        Start = 1'b1; tick(); Start = 1'b0;
        wait_idle(300, "busy_start");
        checks++;
        if (cd_cnt - cd0 != NUM_COLS || sd_cnt - sd0 != 1) begin
            errors++;
            $display("FAIL busy_start_pulses: coldone=%0d scandone=%0d, want %0d/1", cd_cnt - cd0, sd_cnt - sd0, NUM_COLS);
        end
    endtask

    task automatic test_iter_zero();
        int cd0 = cd_cnt, sd0 = sd_cnt;
        push_scan(0);
        pulse_start(0);
        wait_idle(300, "iter0");
        checks++;
        if (cd_cnt - cd0 != NUM_COLS || sd_cnt - sd0 != 1 || IterIdx !== IT_W'(1)) begin
            errors++;
            $display("FAIL iter0_pulses: coldone=%0d scandone=%0d it=%0d, want %0d/1/1", cd_cnt - cd0, sd_cnt - sd0, IterIdx, NUM_COLS);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        pulse_start(2);
        while (!DDC && n < 50) begin tick(); n++; end
        Reset = 1'b1;
        #1;
        checks++;
        if ({DDR, DDC, Busy} !== 3'b0 || Column !== '0) begin
            errors++;
            $display("FAIL reset_mid: ddr=%b ddc=%b busy=%b col=%0d, want 0/0/0/0", DDR, DDC, Busy, Column);
        end
        prev_ddr = 1'b0;
        prev_ddc = 1'b0;
        exp_q.delete();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || DDR !== 1'b0) begin errors++; $display("FAIL reset_start: busy=%b ddr=%b, want 0/0", Busy, DDR); end
        Reset = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || IterIdx !== '0) begin errors++; $display("FAIL reset_after: busy=%b it=%0d, want 0/0", Busy, IterIdx); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_full_scan();
        test_drain();
        test_stop_mid();
        test_start_busy();
        test_iter_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
